// File: rtl/telemetry_rx.sv
// Telemetry link receiver: 8N1 UART deserializer feeding a packet framer that
// recognises 0xAA 0x55 headers and publishes registered 12-bit telemetry fields.
module telemetry_rx #(
  parameter int BAUD_DIV = 2604,
  parameter int TO_BITS  = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RX,
  output logic [11:0] batt_v,
  output logic [11:0] avg_curr,
  output logic [11:0] avg_torque,
  output logic        pkt_vld,
  output logic        pkt_err,
  output logic [7:0]  pkt_cnt
);

  // Half-bit load is one short to absorb the cycle spent detecting the edge.
  localparam logic [15:0] HALF_LD  = 16'(BAUD_DIV / 2 - 1);
  localparam logic [15:0] BIT_LD   = 16'(BAUD_DIV - 1);
  localparam logic [21:0] TO_LIMIT = 22'(TO_BITS * BAUD_DIV);

  typedef enum logic [1:0] {B_IDLE, B_START, B_DATA, B_STOP} bstate_t;
  typedef enum logic [1:0] {P_WAIT_AA, P_WAIT_55, P_PAYLOAD} pstate_t;

  logic        rx_s1, rx_s2, rx_prev;
  bstate_t     bstate, b_nxt;
  logic [15:0] bit_cnt, cnt_nxt;
  logic [2:0]  bit_idx, idx_nxt;
  logic [7:0]  shreg, sh_nxt;
  logic        byte_rdy, rdy_nxt, frame_err, ferr_nxt;

  pstate_t     pstate, p_nxt;
  logic [2:0]  pidx;
  logic [3:0]  sh_bh, sh_ch, sh_th;
  logic [7:0]  sh_bl, sh_cl;
  logic [21:0] to_cnt;
  logic        to_hit, done;

  // NOTE: sequential state always uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= RX;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  always_comb begin
    // NOTE: every signal gets a default first so no branch can infer a latch.
    b_nxt    = bstate;
    cnt_nxt  = bit_cnt;
    idx_nxt  = bit_idx;
    sh_nxt   = shreg;
    rdy_nxt  = 1'b0;
    ferr_nxt = 1'b0;
    case (bstate)
      B_IDLE: if (!rx_s2 && rx_prev) begin
        b_nxt   = B_START;
        cnt_nxt = HALF_LD;
      end
      B_START: if (bit_cnt == 16'd0) begin
        b_nxt   = rx_s2 ? B_IDLE : B_DATA;
        cnt_nxt = BIT_LD;
        idx_nxt = 3'd0;
      end else cnt_nxt = bit_cnt - 16'd1;
      B_DATA: if (bit_cnt == 16'd0) begin
        sh_nxt  = {rx_s2, shreg[7:1]};
        cnt_nxt = BIT_LD;
        idx_nxt = bit_idx + 3'd1;
        if (bit_idx == 3'd7) b_nxt = B_STOP;
      end else cnt_nxt = bit_cnt - 16'd1;
      B_STOP: if (bit_cnt == 16'd0) begin
        b_nxt    = B_IDLE;
        rdy_nxt  = rx_s2;
        ferr_nxt = !rx_s2;
      end else cnt_nxt = bit_cnt - 16'd1;
      default: b_nxt = B_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bstate    <= B_IDLE;
      bit_cnt   <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      byte_rdy  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      bstate    <= b_nxt;
      bit_cnt   <= cnt_nxt;
      bit_idx   <= idx_nxt;
      shreg     <= sh_nxt;
      byte_rdy  <= rdy_nxt;
      frame_err <= ferr_nxt;
    end
  end

  // A byte arriving in the same cycle the idle limit is reached wins.
  assign to_hit = (pstate != P_WAIT_AA) && (bstate == B_IDLE) && !byte_rdy &&
                  (to_cnt == TO_LIMIT - 22'd1);
  assign done   = byte_rdy && (pstate == P_PAYLOAD) && (pidx == 3'd5);

  always_comb begin
    p_nxt = pstate;
    if (frame_err || to_hit) p_nxt = P_WAIT_AA;
    else if (byte_rdy) begin
      case (pstate)
        P_WAIT_AA: if (shreg == 8'hAA) p_nxt = P_WAIT_55;
        P_WAIT_55: begin
          if (shreg == 8'h55)      p_nxt = P_PAYLOAD;
          else if (shreg != 8'hAA) p_nxt = P_WAIT_AA;
        end
        P_PAYLOAD: if (pidx == 3'd5) p_nxt = P_WAIT_AA;
        default:   p_nxt = P_WAIT_AA;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pstate <= P_WAIT_AA;
      pidx   <= '0;
      to_cnt <= '0;
    end else begin
      pstate <= p_nxt;
      if (byte_rdy && pstate == P_WAIT_55)      pidx <= 3'd0;
      else if (byte_rdy && pstate == P_PAYLOAD) pidx <= pidx + 3'd1;
      if (pstate == P_WAIT_AA || byte_rdy || to_hit) to_cnt <= '0;
      else if (bstate == B_IDLE)                     to_cnt <= to_cnt + 22'd1;
    end
  end

  // NOTE: shadow bytes carry no reset; they reach the outputs only after a
  // complete packet has rewritten every one of them.
  always_ff @(posedge clk) begin
    if (byte_rdy && pstate == P_PAYLOAD) begin
      case (pidx)
        3'd0:    sh_bh <= shreg[3:0];
        3'd1:    sh_bl <= shreg;
        3'd2:    sh_ch <= shreg[3:0];
        3'd3:    sh_cl <= shreg;
        3'd4:    sh_th <= shreg[3:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      batt_v     <= '0;
      avg_curr   <= '0;
      avg_torque <= '0;
      pkt_cnt    <= '0;
      pkt_vld    <= 1'b0;
      pkt_err    <= 1'b0;
    end else begin
      if (done) begin
        batt_v     <= {sh_bh, sh_bl};
        avg_curr   <= {sh_ch, sh_cl};
        avg_torque <= {sh_th, shreg};
        pkt_cnt    <= pkt_cnt + 8'd1;
      end
      pkt_vld <= done;
      pkt_err <= frame_err || to_hit;
    end
  end

endmodule
